// File: rtl/apb_slv_pkg.sv
// Shared types and widths for the APB wait-state completer.
// Holds the FSM state encoding and default bus/counter widths.
package apb_slv_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } slv_state_e;
endpackage

// File: rtl/apb_wait_slave_if.sv
// APB3 bus between the bridge (master) and a completer (slave).
// Request: PSEL PENABLE PWRITE PADDR PWDATA; response: PREADY PRDATA PSLVERR.
interface apb_wait_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_slv_mem.sv
// DEPTH x DATA_W register file: sync write, comb read, sync clear on rst.
// Ports: clk, rst, we, waddr, wdata, raddr -> rdata (0 when out of range).
module apb_slv_mem #(
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && int'(waddr) < DEPTH) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer: register file with WAIT_CYCLES wait states, PSLVERR, err_count.
// Ports: PCLK, PRESET (sync, active-high), bus (slave modport), err_count.
// Macro APB_WAIT_SLAVE_RO_REGION_EN makes RO_BASE..DEPTH-1 read-only.
module apb_wait_slave
    import apb_slv_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 192,
    parameter int WAIT_CYCLES = 2,
    parameter int RO_BASE     = 160
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_wait_slave_if.slave      bus,
    output logic [ERR_CNT_W-1:0] err_count
);
`ifdef APB_WAIT_SLAVE_RO_REGION_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    slv_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  mism_q, mism_d;
    logic                  ready_q, ready_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  ecnt_q, ecnt_d;

    logic                  resp;
    logic                  resp_mism;
    logic                  resp_err;
    logic                  mem_we;
    logic [ADDR_W-1:0]     resp_addr;
    logic                  resp_wr;
    logic [DATA_W-1:0]     mem_rdata;

    // With zero waits the response is built from the live setup phase.
    assign resp_addr = (state_q == IDLE) ? bus.PADDR : addr_q;
    assign resp_wr   = (state_q == IDLE) ? bus.PWRITE : wr_q;

    apb_slv_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk  (PCLK),
        .rst  (PRESET),
        .we   (mem_we),
        .waddr(addr_q),
        .wdata(wdata_q),
        .raddr(resp_addr),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        mism_d    = mism_q;
        ready_d   = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        ecnt_d    = ecnt_q;
        mem_we    = 1'b0;
        resp      = 1'b0;
        resp_mism = mism_q;
        resp_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    addr_d    = bus.PADDR;
                    wr_d      = bus.PWRITE;
                    wdata_d   = bus.PWDATA;
                    mism_d    = 1'b0;
                    resp_mism = 1'b0;
                    cnt_d     = WAIT_L;
                    if (WAIT_L == 4'd0) begin
                        resp = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else begin
                    // Any drift of address/control is sticky until the response.
                    resp_mism = mism_q || !bus.PENABLE
                             || (bus.PADDR != addr_q)
                             || (bus.PWRITE != wr_q);
                    mism_d = resp_mism;
                    if (cnt_q <= 4'd1) begin
                        resp = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                mem_we  = wr_q && !err_q;
            end
            default: state_d = IDLE;
        endcase

        if (resp) begin
            resp_err = (int'(resp_addr) >= DEPTH) || resp_mism
                    || (RO_EN && resp_wr && int'(resp_addr) >= RO_BASE);
            state_d  = RESP;
            ready_d  = 1'b1;
            err_d    = resp_err;
            rdata_d  = (!resp_err && !resp_wr) ? mem_rdata : '0;
            if (resp_err && ecnt_q != '1) begin
                ecnt_d = ecnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mism_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            mism_q  <= mism_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign bus.PREADY  = ready_q;
    assign bus.PRDATA  = rdata_q;
    assign bus.PSLVERR = err_q;
    assign err_count   = ecnt_q;
endmodule
